// File: rtl/sdio_pkg.sv
// rtl/sdio_pkg.sv - shared types, constants and CRC7 step for the SD CMD-line host
package sdio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_WAIT,
    ST_RX,
    ST_FIN,
    ST_GAP
  } state_e;

  localparam logic [1:0] RESP_NONE      = 2'd0;
  localparam logic [1:0] RESP_R48       = 2'd1;
  localparam logic [1:0] RESP_R136      = 2'd2;
  localparam logic [1:0] RESP_R48_NOCRC = 2'd3;

  localparam int CMD_SIZE  = 48;
  localparam int RESP_SIZE = 136;

  // One serial step of CRC7, generator x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

endpackage

// File: rtl/sdio_crc7.sv
// rtl/sdio_crc7.sv - serial CRC7 accumulator, MSB-first input
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       din_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      crc_q <= '0;
    end else if (en_i) begin
      crc_q <= crc7_step(crc_q, din_i);
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sdio_cmd_host.sv
// rtl/sdio_cmd_host.sv - SD CMD-line initiator: sends a command frame, optionally
// captures and CRC-checks the response, with response timeout and idle gap.
module sdio_cmd_host
  import sdio_pkg::*;
#(
  parameter int MAXLAT = 64,
  parameter int NCC    = 8
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 sd_en,
  input  logic                 start_i,
  input  logic [5:0]           cmd_idx_i,
  input  logic [31:0]          arg_i,
  input  logic [1:0]           resp_type_i,
  input  logic                 cmd_i,
  output logic                 cmd_o,
  output logic                 cmd_oe_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic                 crc_err_o,
  output logic [RESP_SIZE-1:0] resp_o
);

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [39:0]            tx_q, tx_d;
  logic [1:0]             type_q, type_d;
  logic [RESP_SIZE-2:0]   rsh_q, rsh_d;
  logic [RESP_SIZE-1:0]   resp_q, resp_d;
  logic                   timeout_q, timeout_d;
  logic                   crc_err_q, crc_err_d;

  logic                   srst;
  logic                   crc_clr, crc_en, crc_din;
  logic [6:0]             crc;
  logic [2:0]             crc_sel;
  logic [RESP_SIZE-1:0]   rx_full;

  assign srst = rst | ~sd_en;

  // TX and RX never overlap, so one accumulator serves both directions.
  sdio_crc7 u_crc7 (
    .clk_i (sd_clk),
    .rst_i (srst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .din_i (crc_din),
    .crc_o (crc)
  );

  always_ff @(posedge sd_clk) begin
    if (srst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tx_q      <= '0;
      type_q    <= RESP_NONE;
      rsh_q     <= '0;
      resp_q    <= '0;
      timeout_q <= 1'b0;
      crc_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_q      <= tx_d;
      type_q    <= type_d;
      rsh_q     <= rsh_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      crc_err_q <= crc_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_d      = tx_q;
    type_d    = type_q;
    rsh_d     = rsh_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    crc_err_d = crc_err_q;
    cmd_o     = 1'b1;
    cmd_oe_o  = 1'b0;
    done_o    = 1'b0;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_din   = cmd_i;
    crc_sel   = cnt_q[2:0] - 3'd1;
    rx_full   = {rsh_q, cmd_i};

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_TX;
          cnt_d   = 8'(CMD_SIZE - 1);
          tx_d    = {2'b01, cmd_idx_i, arg_i};
          type_d  = resp_type_i;
          crc_clr = 1'b1;
        end
      end
      ST_TX: begin
        cmd_oe_o = 1'b1;
        if (cnt_q >= 8'd8) begin
          cmd_o   = tx_q[39];
          crc_en  = 1'b1;
          crc_din = tx_q[39];
          tx_d    = {tx_q[38:0], 1'b0};
        end else if (cnt_q != 8'd0) begin
          cmd_o = crc[crc_sel];
        end
        if (cnt_q == 8'd0) begin
          crc_clr = 1'b1;
          if (type_q == RESP_NONE) begin
            state_d   = ST_FIN;
            resp_d    = '0;
            timeout_d = 1'b0;
            crc_err_d = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WAIT: begin
        if (!cmd_i) begin
          // The start bit is a 0 into a cleared CRC, so it needs no explicit update.
          state_d = ST_RX;
          rsh_d   = '0;
          cnt_d   = (type_q == RESP_R136) ? 8'(RESP_SIZE - 2) : 8'(CMD_SIZE - 2);
        end else if (cnt_q == 8'(MAXLAT - 1)) begin
          state_d   = ST_FIN;
          resp_d    = '0;
          timeout_d = 1'b1;
          crc_err_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RX: begin
        rsh_d  = rx_full[RESP_SIZE-2:0];
        crc_en = (cnt_q >= 8'd8) && ((type_q != RESP_R136) || (cnt_q <= 8'd127));
        if (cnt_q == 8'd0) begin
          state_d   = ST_FIN;
          resp_d    = rx_full;
          timeout_d = 1'b0;
          crc_err_d = ((type_q == RESP_R48) || (type_q == RESP_R136)) &&
                      ((rx_full[7:1] != crc) || !rx_full[0]);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_GAP;
        cnt_d   = '0;
      end
      ST_GAP: begin
        if (cnt_q == 8'(NCC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign timeout_o = timeout_q;
  assign crc_err_o = crc_err_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_sdio_cmd_host.sv
// tb/tb_sdio_cmd_host.sv - directed vector bench for sdio_cmd_host
module tb_sdio_cmd_host;

  localparam int MAXLAT = 64;
  localparam int NCC    = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sd_en = 1'b1;
  logic         start_i = 1'b0;
  logic [5:0]   cmd_idx_i = '0;
  logic [31:0]  arg_i = '0;
  logic [1:0]   resp_type_i = '0;
  logic         cmd_i = 1'b1;
  logic         cmd_o, cmd_oe_o, busy_o, done_o, timeout_o, crc_err_o;
  logic [135:0] resp_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdio_cmd_host #(.MAXLAT(MAXLAT), .NCC(NCC)) dut (
    .sd_clk      (clk),
    .rst         (rst),
    .sd_en       (sd_en),
    .start_i     (start_i),
    .cmd_idx_i   (cmd_idx_i),
    .arg_i       (arg_i),
    .resp_type_i (resp_type_i),
    .cmd_i       (cmd_i),
    .cmd_o       (cmd_o),
    .cmd_oe_o    (cmd_oe_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .crc_err_o   (crc_err_o),
    .resp_o      (resp_o)
  );

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    int           lat;     // idle samples before the reply start bit; <0 = no reply
    logic [135:0] reply;
    logic [47:0]  frame;
    logic         to;
    logic         ce;
    logic [135:0] resp;
  } vec_t;

  vec_t vt[9];

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Polynomial long division of the augmented message by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [135:0] data, input int nbits);
    logic [7:0] r;
    r = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      r = {r[6:0], data[i]};
      if (r[7]) r = r ^ 8'h89;
    end
    for (int i = 0; i < 7; i++) begin
      r = {r[6:0], 1'b0};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    body = {2'b01, idx, arg};
    return {body, crc7_ref(136'(body), 40), 1'b1};
  endfunction

  function automatic logic [135:0] mk_r48(input logic [39:0] body, input logic endb);
    return 136'({body, crc7_ref(136'(body), 40), endb});
  endfunction

  task automatic do_start(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt);
    @(negedge clk);
    cmd_idx_i   = idx;
    arg_i       = arg;
    resp_type_i = rt;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i     = 1'b0;
    resp_type_i = ~rt;
    cmd_idx_i   = ~idx;
    arg_i       = ~arg;
  endtask

  task automatic run_txn(input vec_t v, input int n);
    logic [47:0] fr;
    logic        oe_ok, busy_ok;
    int          nb, done_at, exp_done, j;
    fr = '0;
    oe_ok = 1'b1;
    busy_ok = 1'b1;
    do_start(v.idx, v.arg, v.rtype);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      fr = {fr[46:0], cmd_o};
      if (!cmd_oe_o) oe_ok = 1'b0;
      if (!busy_o) busy_ok = 1'b0;
    end
    checkw($sformatf("v%0d tx_frame", n), 136'(fr), 136'(v.frame));
    check1($sformatf("v%0d oe_during_tx", n), oe_ok, 1'b1);
    check1($sformatf("v%0d busy_during_tx", n), busy_ok, 1'b1);

    nb = (v.rtype == 2'd2) ? 136 : 48;
    done_at = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) check1($sformatf("v%0d oe_released", n), cmd_oe_o, 1'b0);
      if (done_o) begin
        done_at = k;
        break;
      end
      if (v.lat >= 0 && k >= v.lat + 1 && k <= v.lat + nb)
        cmd_i = v.reply[nb - 1 - (k - v.lat - 1)];
      else
        cmd_i = 1'b1;
    end
    cmd_i = 1'b1;

    if (v.rtype == 2'd0) exp_done = 1;
    else if (v.lat < 0 || v.lat >= MAXLAT) exp_done = MAXLAT + 1;
    else exp_done = v.lat + 1 + nb;
    check_int($sformatf("v%0d done_cycle", n), done_at, exp_done);
    check1($sformatf("v%0d timeout", n), timeout_o, v.to);
    check1($sformatf("v%0d crc_err", n), crc_err_o, v.ce);
    checkw($sformatf("v%0d resp", n), resp_o, v.resp);

    @(negedge clk);
    check1($sformatf("v%0d done_one_cycle", n), done_o, 1'b0);
    j = 1;
    while (j <= 50) begin
      @(negedge clk);
      if (!busy_o) break;
      j++;
    end
    check_int($sformatf("v%0d gap_len", n), j, NCC);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [119:0] cid_body;
    logic [135:0] cid;
    logic [135:0] r41, r55_bad, r55_ok;
    int           j;
    logic         quiet;

    cid_body = 120'h03_5344_5355_3136_4780_1234_5678_0112;
    cid      = {8'h3F, cid_body, crc7_ref(136'(cid_body), 120), 1'b1};
    r41      = 136'(48'h3F80FF8000FF);
    r55_bad  = mk_r48({8'h37, 32'h0000_0120}, 1'b0);
    r55_ok   = mk_r48({8'h37, 32'h0000_0120}, 1'b1);

    vt[0] = '{6'd0,  32'h0,         2'd0, -1, '0,                         48'h40_00000000_95, 1'b0, 1'b0, '0};
    vt[1] = '{6'd8,  32'h1AA,       2'd1,  5, 136'(48'h08_000001AA_13),   48'h48_000001AA_87, 1'b0, 1'b0, 136'(48'h08_000001AA_13)};
    vt[2] = '{6'd17, 32'h0,         2'd1, -1, '0,                         mk_frame(6'd17, 32'h0), 1'b1, 1'b0, '0};
    vt[3] = '{6'd41, 32'h40FF_8000, 2'd3,  5, r41,                        mk_frame(6'd41, 32'h40FF_8000), 1'b0, 1'b0, r41};
    vt[4] = '{6'd41, 32'h40FF_8000, 2'd1,  5, r41,                        mk_frame(6'd41, 32'h40FF_8000), 1'b0, 1'b1, r41};
    vt[5] = '{6'd2,  32'h0,         2'd2,  2, cid,                        mk_frame(6'd2, 32'h0), 1'b0, 1'b0, cid};
    vt[6] = '{6'd55, 32'h0000_0120, 2'd1, 63, r55_bad,                    mk_frame(6'd55, 32'h0000_0120), 1'b0, 1'b1, r55_bad};
    vt[7] = '{6'd13, 32'h0001_0000, 2'd1, 64, r55_ok,                     mk_frame(6'd13, 32'h0001_0000), 1'b1, 1'b0, '0};
    vt[8] = '{6'd55, 32'h0000_0120, 2'd1,  0, r55_ok,                     mk_frame(6'd55, 32'h0000_0120), 1'b0, 1'b0, r55_ok};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst cmd_o", cmd_o, 1'b1);
    check1("rst cmd_oe_o", cmd_oe_o, 1'b0);
    check1("rst busy_o", busy_o, 1'b0);
    check1("rst done_o", done_o, 1'b0);
    check1("rst timeout_o", timeout_o, 1'b0);
    check1("rst crc_err_o", crc_err_o, 1'b0);
    checkw("rst resp_o", resp_o, '0);

    rst = 1'b0;
    sd_en = 1'b0;
    do_start(6'd8, 32'h1AA, 2'd1);
    @(negedge clk);
    check1("sd_en low busy_o", busy_o, 1'b0);
    check1("sd_en low cmd_oe_o", cmd_oe_o, 1'b0);
    sd_en = 1'b1;

    for (int i = 0; i < 9; i++) run_txn(vt[i], i);

    do_start(6'd8, 32'h1AA, 2'd1);
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("abort cmd_oe_o", cmd_oe_o, 1'b0);
    check1("abort busy_o", busy_o, 1'b0);
    check1("abort cmd_o", cmd_o, 1'b1);
    rst = 1'b0;
    run_txn(vt[1], 9);

    do_start(6'd0, 32'h0, 2'd0);
    repeat (48) @(negedge clk);
    @(negedge clk);
    check1("gap done_o", done_o, 1'b1);
    @(negedge clk);
    cmd_idx_i   = 6'd5;
    resp_type_i = 2'd0;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    j = 1;
    while (j <= 30) begin
      @(negedge clk);
      if (!busy_o) break;
      j++;
    end
    check_int("gap start ignored gap_len", j, NCC);
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (busy_o || cmd_oe_o) quiet = 1'b0;
    end
    check1("gap start not queued", quiet, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
